// File: rtl/reg_scoreboard_pkg.sv
// Register scoreboard shared definitions (package rf_pkg).
// Holds the register file geometry used by the scoreboard, its interface
// and the per-register counter.
//   REG_ADDR_W : width of a register address
//   NUM_REGS   : number of architectural registers
//   CNT_W      : width of each pending-write counter
//   REG_ZERO   : address of the hard-wired zero register
package rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 2;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Register scoreboard bus interface.
// Groups the decode-side issue request, writeback retire, flush and the
// scoreboard status outputs.
//   master : decode/writeback side (drives issue_*, reg_wr*, flush)
//   slave  : scoreboard side (drives stall_flag, issue_accept,
//            pending_mask, sb_error)
// Handshake: an instruction is accepted in a cycle exactly when
// issue_valid is high and stall_flag is low (issue_accept); a stalled
// instruction must be held by decode and is not recorded.
interface reg_scoreboard_if import rf_pkg::*; #(
    parameter int NUM_REGS = rf_pkg::NUM_REGS
);
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_src_addr1;
    logic [REG_ADDR_W-1:0] issue_src_addr2;
    logic                  issue_src_use1;
    logic                  issue_src_use2;
    logic                  issue_wr;
    logic [REG_ADDR_W-1:0] issue_dest_addr;
    logic                  reg_wr;
    logic [REG_ADDR_W-1:0] reg_wr_addr;
    logic                  flush;
    logic                  stall_flag;
    logic                  issue_accept;
    logic [NUM_REGS-1:0]   pending_mask;
    logic                  sb_error;

    modport master (
        output issue_valid, issue_src_addr1, issue_src_addr2,
               issue_src_use1, issue_src_use2, issue_wr, issue_dest_addr,
               reg_wr, reg_wr_addr, flush,
        input  stall_flag, issue_accept, pending_mask, sb_error
    );

    modport slave (
        input  issue_valid, issue_src_addr1, issue_src_addr2,
               issue_src_use1, issue_src_use2, issue_wr, issue_dest_addr,
               reg_wr, reg_wr_addr, flush,
        output stall_flag, issue_accept, pending_mask, sb_error
    );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: saturating up/down pending-write counter for one register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_inc      : accepted issue writing this register
//   i_dec      : retire of this register
//   i_clr      : flush, clears the counter and wins over inc/dec
//   o_count    : current count
//   o_err      : retire seen while count is zero (combinational pulse)
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // A same-cycle issue covers the retire, so only a lone retire at zero
    // is an underflow. Flush cancels everything, including the error.
    assign o_err   = i_dec && !i_inc && !i_clr && (r_count == '0);
    assign o_count = r_count;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight register writes and stalls decode on
// read-after-write hazards or when a destination counter is saturated.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset
//   sb    : reg_scoreboard_if.slave (issue, retire, flush, status)
// Option: define SCOREBOARD_BYPASS_EN to let a source whose only pending
// writer retires in the same cycle proceed without a stall bubble.
module reg_scoreboard import rf_pkg::*; #(
    parameter int NUM_REGS = rf_pkg::NUM_REGS,
    parameter int CNT_W    = rf_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    reg_scoreboard_if.slave    sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_err;
    logic [NUM_REGS-1:0] w_mask;
    logic                w_issue_fire;
    logic                w_stall;
    logic                w_src1_busy, w_src2_busy;
    logic                w_src1_byp, w_src2_byp;
    logic                w_dest_full;
    logic                r_sb_error;

    // Register 0 is hard-wired: never pending, never stalls, never errors.
    assign w_cnt[0] = '0;
    assign w_err[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        logic w_inc;
        logic w_dec;
        assign w_inc = w_issue_fire && sb.issue_wr &&
                       (sb.issue_dest_addr == REG_ADDR_W'(i));
        assign w_dec = sb.reg_wr && (sb.reg_wr_addr == REG_ADDR_W'(i));
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (reset),
            .i_inc   (w_inc),
            .i_dec   (w_dec),
            .i_clr   (sb.flush),
            .o_count (w_cnt[i]),
            .o_err   (w_err[i])
        );
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_mask[i] = (w_cnt[i] != '0);
        end
    end

    assign w_src1_busy = sb.issue_src_use1 && (w_cnt[sb.issue_src_addr1] != '0);
    assign w_src2_busy = sb.issue_src_use2 && (w_cnt[sb.issue_src_addr2] != '0);

`ifdef SCOREBOARD_BYPASS_EN
    // The last outstanding writer retiring this cycle clears the hazard.
    assign w_src1_byp = sb.reg_wr && (sb.reg_wr_addr == sb.issue_src_addr1) &&
                        (w_cnt[sb.issue_src_addr1] == CNT_ONE);
    assign w_src2_byp = sb.reg_wr && (sb.reg_wr_addr == sb.issue_src_addr2) &&
                        (w_cnt[sb.issue_src_addr2] == CNT_ONE);
`else
    assign w_src1_byp = 1'b0;
    assign w_src2_byp = 1'b0;
`endif

    // Stalling on a full destination is what keeps the counters from wrapping.
    assign w_dest_full = sb.issue_wr && (sb.issue_dest_addr != REG_ZERO) &&
                         (w_cnt[sb.issue_dest_addr] == CNT_MAX);

    assign w_stall = sb.issue_valid &&
                     ((w_src1_busy && !w_src1_byp) ||
                      (w_src2_busy && !w_src2_byp) ||
                      w_dest_full);
    assign w_issue_fire = sb.issue_valid && !w_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sb_error <= 1'b0;
        end else if (|w_err) begin
            r_sb_error <= 1'b1;
        end
    end

    assign sb.stall_flag   = w_stall;
    assign sb.issue_accept = w_issue_fire;
    assign sb.pending_mask = w_mask;
    assign sb.sb_error     = r_sb_error;
endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

`ifdef SCOREBOARD_BYPASS_EN
    localparam logic BYP_STALL = 1'b0;
`else
    localparam logic BYP_STALL = 1'b1;
`endif

    always #5 clk = ~clk;

    reg_scoreboard_if #(.NUM_REGS(32)) sb_if ();

    reg_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    task automatic idle();
        sb_if.issue_valid     = 1'b0;
        sb_if.issue_src_addr1 = '0;
        sb_if.issue_src_addr2 = '0;
        sb_if.issue_src_use1  = 1'b0;
        sb_if.issue_src_use2  = 1'b0;
        sb_if.issue_wr        = 1'b0;
        sb_if.issue_dest_addr = '0;
        sb_if.reg_wr          = 1'b0;
        sb_if.reg_wr_addr     = '0;
        sb_if.flush           = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [4:0] dest,
                         input logic u1, input logic [4:0] s1,
                         input logic u2, input logic [4:0] s2);
        sb_if.issue_valid     = 1'b1;
        sb_if.issue_wr        = wr;
        sb_if.issue_dest_addr = dest;
        sb_if.issue_src_use1  = u1;
        sb_if.issue_src_addr1 = s1;
        sb_if.issue_src_use2  = u2;
        sb_if.issue_src_addr2 = s2;
    endtask

    task automatic retire(input logic [4:0] a);
        sb_if.reg_wr      = 1'b1;
        sb_if.reg_wr_addr = a;
    endtask

    // Advance past the next active edge; registered outputs are stable after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        #1;
        checks++;
        if (sb_if.pending_mask !== 32'h0) begin
            errors++; $display("FAIL reset_mask got %h exp 0", sb_if.pending_mask);
        end
        checks++;
        if (sb_if.sb_error !== 1'b0) begin
            errors++; $display("FAIL reset_err got %b exp 0", sb_if.sb_error);
        end
        checks++;
        if (sb_if.stall_flag !== 1'b0 || sb_if.issue_accept !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b/%b exp 0/0", sb_if.stall_flag, sb_if.issue_accept);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_raw_hazard();
        issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        checks++;
        if (sb_if.issue_accept !== 1'b1 || sb_if.stall_flag !== 1'b0) begin
            errors++; $display("FAIL raw_accept got %b/%b exp 1/0", sb_if.issue_accept, sb_if.stall_flag);
        end
        tick();
        idle();
        issue(1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
        #1;
        checks++;
        if (sb_if.pending_mask !== 32'h0000_0020) begin
            errors++; $display("FAIL raw_mask5 got %h exp 00000020", sb_if.pending_mask);
        end
        checks++;
        if (sb_if.stall_flag !== 1'b1 || sb_if.issue_accept !== 1'b0) begin
            errors++; $display("FAIL raw_stall got %b/%b exp 1/0", sb_if.stall_flag, sb_if.issue_accept);
        end
        tick();
        retire(5'd5);
        #1;
        checks++;
        if (sb_if.stall_flag !== BYP_STALL) begin
            errors++; $display("FAIL raw_retire_stall got %b exp %b", sb_if.stall_flag, BYP_STALL);
        end
        tick();
        sb_if.reg_wr = 1'b0;
        #1;
        checks++;
        if (sb_if.pending_mask !== 32'h0 || sb_if.stall_flag !== 1'b0) begin
            errors++; $display("FAIL raw_release got mask %h stall %b exp 0/0", sb_if.pending_mask, sb_if.stall_flag);
        end
        tick();
        idle();
        checks++;
        if (sb_if.sb_error !== 1'b0) begin
            errors++; $display("FAIL raw_err got %b exp 0", sb_if.sb_error);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 3; k++) begin
            issue(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
            #1;
            checks++;
            if (sb_if.issue_accept !== 1'b1) begin
                errors++; $display("FAIL sat_accept%0d got %b exp 1", k, sb_if.issue_accept);
            end
            tick();
        end
        #1;
        checks++;
        if (sb_if.stall_flag !== 1'b1 || sb_if.issue_accept !== 1'b0) begin
            errors++; $display("FAIL sat_full_stall got %b/%b exp 1/0", sb_if.stall_flag, sb_if.issue_accept);
        end
        tick();
        idle();
        // Three retires must empty the counter exactly, with no underflow.
        for (int k = 0; k < 3; k++) begin
            retire(5'd7);
            tick();
            checks++;
            if (sb_if.pending_mask[7] !== (k < 2)) begin
                errors++; $display("FAIL sat_drain%0d got %b exp %b", k, sb_if.pending_mask[7], (k < 2));
            end
        end
        idle();
        checks++;
        if (sb_if.sb_error !== 1'b0) begin
            errors++; $display("FAIL sat_err got %b exp 0", sb_if.sb_error);
        end
    endtask

    task automatic test_same_cycle();
        issue(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        retire(5'd4);
        #1;
        checks++;
        if (sb_if.issue_accept !== 1'b1) begin
            errors++; $display("FAIL same_accept got %b exp 1", sb_if.issue_accept);
        end
        tick();
        idle();
        checks++;
        if (sb_if.pending_mask !== 32'h0000_0010) begin
            errors++; $display("FAIL same_mask got %h exp 00000010", sb_if.pending_mask);
        end
        retire(5'd4);
        tick();
        idle();
        checks++;
        if (sb_if.pending_mask !== 32'h0 || sb_if.sb_error !== 1'b0) begin
            errors++; $display("FAIL same_count1 got mask %h err %b exp 0/0", sb_if.pending_mask, sb_if.sb_error);
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        issue(1'b1, 5'd11, 1'b0, 5'd0, 1'b1, 5'd10);
        #1;
        checks++;
        if (sb_if.stall_flag !== 1'b1) begin
            errors++; $display("FAIL b2b_src2_stall got %b exp 1", sb_if.stall_flag);
        end
        tick();
        checks++;
        if (sb_if.pending_mask !== 32'h0000_0400) begin
            errors++; $display("FAIL b2b_mask got %h exp 00000400", sb_if.pending_mask);
        end
        idle();
        retire(5'd10);
        tick();
        idle();
    endtask

    task automatic test_error();
        retire(5'd0);
        tick();
        idle();
        checks++;
        if (sb_if.sb_error !== 1'b0) begin
            errors++; $display("FAIL err_r0 got %b exp 0", sb_if.sb_error);
        end
        retire(5'd9);
        tick();
        idle();
        checks++;
        if (sb_if.sb_error !== 1'b1 || sb_if.pending_mask !== 32'h0) begin
            errors++; $display("FAIL err_r9 got err %b mask %h exp 1/0", sb_if.sb_error, sb_if.pending_mask);
        end
        repeat (2) tick();
        checks++;
        if (sb_if.sb_error !== 1'b1) begin
            errors++; $display("FAIL err_sticky got %b exp 1", sb_if.sb_error);
        end
        do_reset();
        checks++;
        if (sb_if.sb_error !== 1'b0) begin
            errors++; $display("FAIL err_cleared got %b exp 0", sb_if.sb_error);
        end
    endtask

    task automatic test_flush();
        issue(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        issue(1'b1, 5'd15, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        issue(1'b1, 5'd16, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        issue(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
        retire(5'd15);
        sb_if.flush = 1'b1;
        #1;
        checks++;
        if (sb_if.pending_mask !== 32'h0001_8008) begin
            errors++; $display("FAIL flush_pre_mask got %h exp 00018008", sb_if.pending_mask);
        end
        checks++;
        if (sb_if.issue_accept !== 1'b1) begin
            errors++; $display("FAIL flush_accept got %b exp 1", sb_if.issue_accept);
        end
        tick();
        idle();
        checks++;
        if (sb_if.pending_mask !== 32'h0 || sb_if.sb_error !== 1'b0) begin
            errors++; $display("FAIL flush_clear got mask %h err %b exp 0/0", sb_if.pending_mask, sb_if.sb_error);
        end
        // Pre-flush state still governs stall in the flush cycle.
        issue(1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        issue(1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 5'd0);
        sb_if.flush = 1'b1;
        #1;
        checks++;
        if (sb_if.stall_flag !== 1'b1) begin
            errors++; $display("FAIL flush_prestate_stall got %b exp 1", sb_if.stall_flag);
        end
        tick();
        idle();
        #1;
        checks++;
        if (sb_if.pending_mask !== 32'h0) begin
            errors++; $display("FAIL flush_clear2 got %h exp 0", sb_if.pending_mask);
        end
    endtask

    task automatic test_bypass_and_async_reset();
        issue(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        issue(1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 5'd0);
        retire(5'd6);
        #1;
        checks++;
        if (sb_if.stall_flag !== BYP_STALL) begin
            errors++; $display("FAIL byp_stall got %b exp %b", sb_if.stall_flag, BYP_STALL);
        end
        tick();
        idle();
        checks++;
        if (sb_if.pending_mask !== 32'h0) begin
            errors++; $display("FAIL byp_mask got %h exp 0", sb_if.pending_mask);
        end
        issue(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        issue(1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle();
        checks++;
        if (sb_if.pending_mask !== 32'h0000_0140) begin
            errors++; $display("FAIL arst_pre_mask got %h exp 00000140", sb_if.pending_mask);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (sb_if.pending_mask !== 32'h0) begin
            errors++; $display("FAIL arst_mask got %h exp 0", sb_if.pending_mask);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (sb_if.sb_error !== 1'b0 || sb_if.pending_mask !== 32'h0) begin
            errors++; $display("FAIL arst_after got err %b mask %h exp 0/0", sb_if.sb_error, sb_if.pending_mask);
        end
        // Tracking was discarded, so a retire of r6 now underflows afresh.
        retire(5'd6);
        tick();
        idle();
        checks++;
        if (sb_if.sb_error !== 1'b1) begin
            errors++; $display("FAIL arst_fresh_err got %b exp 1", sb_if.sb_error);
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_raw_hazard();
        test_saturate();
        test_same_cycle();
        test_back_to_back();
        test_error();
        test_flush();
        test_bypass_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32: number of architectural registers tracked.
REQ-002 Parameter CNT_W, default 2: width of the per-register pending-write counter (max in-flight writers = 2^CNT_W-1).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 issue_valid  input  1  decode presents an instruction this cycle.
REQ-006 issue_src_addr1 / issue_src_addr2  input  5 each  source register addresses.
REQ-007 issue_src_use1 / issue_src_use2  input  1 each  source is actually read.
REQ-008 issue_wr  input  1  instruction writes a destination register.
REQ-009 issue_dest_addr  input  5  destination register address.
REQ-010 reg_wr  input  1  writeback retiring a write this cycle.
REQ-011 reg_wr_addr  input  5  address being retired.
REQ-012 flush  input  1  pipeline flush; all in-flight writes cancelled.
REQ-013 stall_flag  output  1  decode must hold; instruction not accepted.
REQ-014 issue_accept  output  1  issue_valid && !stall_flag.
REQ-015 pending_mask  output  NUM_REGS  bit i set when register i counter nonzero.
REQ-016 sb_error  output  1  sticky: retire seen for a register with zero count.

Function
REQ-017 One CNT_W-bit counter per register; register 0 counter is held at 0, never pending, never stalls.
REQ-018 stall_flag combinational from current counters and issue inputs: asserted when issue_valid and (used source pending, or issue_wr with dest counter at max).
REQ-019 stall_flag deasserted whenever issue_valid is 0.
REQ-020 Accepted issue with issue_wr and nonzero dest: dest counter +1 at next posedge.
REQ-021 reg_wr with nonzero reg_wr_addr and count>0: counter -1 at next posedge.
REQ-022 Accepted issue and retire to same register in same cycle: counter unchanged.
REQ-023 Retire to a register with count 0 (and no same-cycle issue to it): counter stays 0, sb_error set and held until reset.
REQ-024 Retire to register 0 ignored, no error.
REQ-025 flush: all counters cleared at next posedge; flush overrides same-cycle issue and retire; stall_flag still evaluated from pre-flush state that cycle.
REQ-026 Counter never wraps: saturation prevented by REQ-018 stall.
REQ-027 pending_mask registered-state view, updates one cycle after the causing event.

Reset
REQ-028 reset low: all counters 0, pending_mask 0, sb_error 0 asynchronously; stall_flag then follows REQ-018 (0 for idle inputs).
REQ-029 Reset mid-operation discards all in-flight tracking; no retire after reset release raises sb_error unless REQ-023 applies afresh.

Configuration
REQ-030 Macro SCOREBOARD_BYPASS_EN defined: a used source whose count is exactly 1 and is retired in the same cycle (reg_wr, matching address) does not cause stall.
REQ-031 Macro undefined: any pending used source stalls regardless of same-cycle retire (one extra bubble).

Structure
REQ-032 Shared package rf_pkg holds REG_ADDR_W=5, NUM_REGS=32, CNT_W=2, REG_ZERO=0.
REQ-033 One sub-module sb_counter: CNT_W up/down counter with inc, dec, clr, async active-low reset, error output.

Verification
REQ-034 Issue wr r5 accepted; next cycle issue reading r5 -> stall_flag=1, pending_mask[5]=1; reg_wr r5 -> mask[5]=0 next cycle, stall drops.
REQ-035 Three accepted writes to r7 without retire -> count 3; fourth issue_wr r7 -> stall_flag=1, count remains 3.
REQ-036 Same-cycle accepted issue wr r4 and reg_wr r4 with count 1 -> count stays 1.
REQ-037 reg_wr r9 with count 0 -> sb_error=1, persists; reg_wr r0 alone -> sb_error stays 0.
REQ-038 Counts on r3,r15,r16 nonzero, flush=1 with issue wr r3 -> all counts 0 next cycle, pending_mask=0.
REQ-039 r6 count 1, issue reads r6 while reg_wr r6: stall_flag=0 with SCOREBOARD_BYPASS_EN, 1 without; async reset low mid-sequence -> mask=0 immediately.
